// File: rtl/pipe_stage_pkg.sv
// rtl/pipe_stage_pkg.sv - shared types and constants for the pipeline-stage buffer
//
// Purpose : occupancy type, statistics counter width and saturation constant,
//           plus small helpers shared by pipe_stage_buf and pipe_stage_slot.
// Ports   : none (package).
// Macro   : PIPE_STAGE_STATS_EN (consumed by pipe_stage_buf).

package pipe_stage_pkg;

  typedef logic [1:0] occ_t;

  localparam int STAT_W = 32;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Saturating increment used by the stall/bubble counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                input logic              en);
    if (en && (v != STAT_MAX)) begin
      return v + 1'b1;
    end
    return v;
  endfunction

  // Entries fill head first, so skid valid implies head valid; this encodes
  // the two valid bits as a count without an adder.
  function automatic occ_t occ_from_valid(input logic h_valid,
                                          input logic s_valid);
    return {s_valid, h_valid & ~s_valid};
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// rtl/pipe_stage_slot.sv - one valid+payload storage entry
//
// Purpose : a single buffer entry. Flush zeroes valid and payload; load
//           captures d and sets valid; clear drops valid but keeps the payload.
// Ports   : clk    in        rising-edge clock
//           reset  in        asynchronous active-low reset
//           flush  in        synchronous kill (highest priority)
//           load   in        capture d, mark valid
//           clear  in        mark invalid, payload holds
//           d      in  WIDTH payload to capture
//           valid  out       entry holds a payload
//           q      out WIDTH stored payload

module pipe_stage_slot
  import pipe_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= d;
    end else if (clear) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign q     = r_data;

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - valid/ready pipeline-stage register with optional skid entry
//
// Purpose : WIDTH-bit pipeline register between two datapath stages. SKID=1
//           uses head+skid entries with in_ready straight from a flop; SKID=0
//           uses one entry with combinational in_ready.
// Macro   : PIPE_STAGE_STATS_EN enables the stall/bubble counters; otherwise
//           stall_cnt/bubble_cnt are tied to zero.
// Ports   : clk        in        rising-edge clock
//           reset      in        asynchronous active-low reset
//           flush      in        synchronous kill of all entries
//           in_valid   in        upstream payload present
//           in_ready   out       stage can accept this cycle
//           in_data    in  WIDTH upstream payload
//           out_valid  out       head entry valid
//           out_ready  in        downstream takes head entry
//           out_data   out WIDTH head payload
//           occupancy  out 2     valid entry count
//           stall_cnt  out 32    cycles with out_valid && !out_ready
//           bubble_cnt out 32    cycles with out_ready && !out_valid

module pipe_stage_buf
  import pipe_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SKID  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output occ_t              occupancy,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] bubble_cnt
);

  logic             w_accept;
  logic             w_pop;
  logic             w_h_valid;
  logic [WIDTH-1:0] w_h_data;
  logic             w_h_load;
  logic             w_h_clear;
  logic [WIDTH-1:0] w_h_d;

  assign w_accept  = in_valid && in_ready;
  assign w_pop     = w_h_valid && out_ready;
  assign out_valid = w_h_valid;
  assign out_data  = w_h_data;

  pipe_stage_slot #(.WIDTH(WIDTH)) u_head (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .load  (w_h_load),
    .clear (w_h_clear),
    .d     (w_h_d),
    .valid (w_h_valid),
    .q     (w_h_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic             w_s_valid;
      logic [WIDTH-1:0] w_s_data;
      logic             w_s_load;
      logic             w_s_clear;

      // Head refills from the skid entry when it holds data, otherwise from
      // the input. An accept cannot coincide with a full skid since in_ready
      // is low then, so the two sources never compete.
      assign w_h_load  = (!w_h_valid && w_accept) ||
                         (w_pop && (w_s_valid || w_accept));
      assign w_h_d     = w_s_valid ? w_s_data : in_data;
      assign w_h_clear = w_pop && !w_s_valid && !w_accept;

      assign w_s_load  = w_h_valid && !w_pop && w_accept;
      assign w_s_clear = w_pop && w_s_valid;

      pipe_stage_slot #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .load  (w_s_load),
        .clear (w_s_clear),
        .d     (in_data),
        .valid (w_s_valid),
        .q     (w_s_data)
      );

      // Registered ready: the skid valid flop itself. The skid entry absorbs
      // the one beat that arrives while upstream still sees the old ready.
      assign in_ready  = !w_s_valid;
      assign occupancy = occ_from_valid(w_h_valid, w_s_valid);
    end else begin : g_single
      assign w_h_load  = w_accept;
      assign w_h_d     = in_data;
      assign w_h_clear = w_pop && !w_accept;
      assign in_ready  = !w_h_valid || out_ready;
      assign occupancy = occ_from_valid(w_h_valid, 1'b0);
    end
  endgenerate

`ifdef PIPE_STAGE_STATS_EN
  logic [STAT_W-1:0] r_stall_cnt;
  logic [STAT_W-1:0] r_bubble_cnt;

  // Reset-only clear: flush kills payloads but not the statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_stall_cnt  <= sat_inc(r_stall_cnt,  w_h_valid && !out_ready);
      r_bubble_cnt <= sat_inc(r_bubble_cnt, out_ready && !w_h_valid);
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage register for the CPU datapath, replacing hand-listed per-field stage registers with one WIDTH-bit packed payload. It uses a valid/ready handshake instead of a bare enable, so stalls propagate backward one stage per cycle. Synchronous flush replaces the old clear. An optional two-entry skid mode gives a registered `in_ready` for timing closure. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- `WIDTH`, default 32: payload width in bits; legal range ≥ 1.
- `SKID`, default 1: 1 selects a two-entry skid buffer with registered `in_ready`; 0 selects a single entry with combinational `in_ready`.

Ports:
- `clk`  in  1  rising-edge clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of all held entries.
- `in_valid`  in  1  upstream has a payload.
- `in_ready`  out  1  the stage can accept a payload this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  the head entry is valid.
- `out_ready`  in  1  downstream accepts the head entry.
- `out_data`  out  WIDTH  head payload.
- `occupancy`  out  2  number of valid entries: 0..2 when SKID=1, 0..1 when SKID=0.
- `stall_cnt`  out  32  cycles with `out_valid && !out_ready` (stats build only).
- `bubble_cnt`  out  32  cycles with `out_ready && !out_valid` (stats build only).

## Operation
- Accept event: `in_valid && in_ready`. Pop event: `out_valid && out_ready`.
- SKID=0:
  - `in_ready = !out_valid || out_ready`.
  - On accept, the head register loads `in_data` and `out_valid` becomes 1.
  - A pop without an accept clears `out_valid`.
- SKID=1 has two entries, head (H) and skid (S). `in_ready = !S.valid` and comes directly from a flop.
  - H empty, accept: H ← in.
  - H full, pop, S empty, accept: H ← in.
  - H full, pop, S full: H ← S; S is emptied. No accept can occur because `in_ready=0`.
  - H full, no pop, accept: S ← in.
  - H full, pop, no accept, S empty: H is emptied.
- Ordering is strictly FIFO. Payloads are never duplicated or dropped, except on flush.
- Payload registers load only on a load event. Otherwise they hold their value, including while invalid.
- Flush has priority over every other event.
  - At the next edge, all valid bits and all payload registers become 0.
  - An accept handshake in the flush cycle completes, but its data is discarded.
  - A pop in the flush cycle is consumed by downstream normally.
- Reset (asynchronous, active-low):
  - `out_valid=0`, `out_data=0`, `occupancy=0`, both counters 0.
  - `in_ready=1` in both modes.
  - Reset mid-transfer discards all entries.

## Timing
- Latency is 1 cycle: a payload accepted at edge N is visible on `out_data` with `out_valid=1` after edge N.
- Throughput is 1 payload per cycle with `out_ready` held at 1, in both modes.
- SKID=1: `in_ready` deasserts the cycle after S fills. It reasserts the cycle after S drains, so upstream sees one cycle of backpressure lag, which the skid absorbs.
- SKID=0: `in_ready` has a combinational path from `out_ready`.
- `occupancy` is registered and reflects state after the most recent edge.

## Configuration
- Macro `PIPE_STAGE_STATS_EN`.
- Defined: `stall_cnt` and `bubble_cnt` increment on their conditions.
  - Both saturate at 2^32−1.
  - Both are cleared by reset only; flush does not clear them.
- Undefined: both ports remain present and are tied to 0. No counter flops are synthesised.

## Structure
- Shared package `pipe_stage_pkg`:
  - `occ_t` (2-bit occupancy typedef).
  - `STAT_W = 32`.
  - `STAT_MAX` saturation constant.
- Sub-module `pipe_stage_slot`: one valid+payload entry with `load`, `clear` and `d` inputs. It is instantiated once for H, and again for S when SKID=1.
- Counter logic lives inline under the macro guard.

## Test plan
- Streaming, SKID=1, `out_ready=1`: in 0x11, 0x22, 0x33 on consecutive cycles -> out 0x11, 0x22, 0x33 one cycle later each; `occupancy` stays at 1; `in_ready` stays 1.
- Backpressure, SKID=1: hold `out_ready=0` and push 0xA, 0xB, 0xC -> 0xA in H, 0xB in S; `in_ready=0` after the second accept; 0xC held upstream. Release -> out 0xA, 0xB, 0xC in order with no loss.
- SKID=0, `out_ready` toggled 1,0,1,0 with `in_valid` held at 1 -> `in_ready` follows `out_ready` combinationally while full; every payload appears exactly once.
- Flush with `occupancy=2` and a simultaneous accept of 0x55 -> next cycle `out_valid=0`, `occupancy=0`, `out_data=0`; 0x55 never appears.
- Reset asserted mid-stream with `occupancy=2` -> immediately (without waiting for a clock edge) `out_valid=0` and `in_ready=1`; after release, 0x77 passes with 1-cycle latency.
- With `PIPE_STAGE_STATS_EN`: 5 cycles of `out_valid=1, out_ready=0` followed by 3 idle cycles with `out_ready=1` -> `stall_cnt=5`, `bubble_cnt=3`. Without the macro -> both read 0.
